// File: rtl/da_dct_pkg.sv
// Shared types, DCT constants and the partial-sum helper for the DA DCT engine.
package da_dct_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} da_state_e;

    // cos(k*pi/16) in Q1.14
    localparam logic signed [15:0] C1 = 16'sh3EC5;
    localparam logic signed [15:0] C2 = 16'sh3B21;
    localparam logic signed [15:0] C3 = 16'sh3537;
    localparam logic signed [15:0] C4 = 16'sh2D41;
    localparam logic signed [15:0] C5 = 16'sh238E;
    localparam logic signed [15:0] C6 = 16'sh187E;
    localparam logic signed [15:0] C7 = 16'sh0C7C;

    localparam int unsigned MAX_TAPS = 6;

    typedef logic signed [31:0] coef_t;
    typedef coef_t coef_arr_t [MAX_TAPS];

    // Sum of the coefficients selected by the set bits of addr.
    function automatic logic signed [63:0] lut_entry(input int unsigned addr,
                                                      input coef_arr_t coef);
        logic signed [63:0] sum;
        sum = '0;
        for (int k = 0; k < MAX_TAPS; k++) begin
            if (addr[k]) sum = sum + 64'(coef[k]);
        end
        return sum;
    endfunction

endpackage

// File: rtl/da_lut.sv
// Combinational 2^N_TAPS-entry partial-sum table, built at elaboration from COEF.
module da_lut
    import da_dct_pkg::*;
#(
    parameter int unsigned N_TAPS = 4,
    parameter int unsigned COEF_W = 16,
    parameter int unsigned ACC_W  = 32,
    parameter logic signed [COEF_W-1:0] COEF [N_TAPS] =
        '{16'sh2D41, 16'shD2BF, 16'shD2BF, 16'sh2D41}
) (
    input  logic [N_TAPS-1:0]       addr,
    output logic signed [ACC_W-1:0] value
);

    function automatic coef_arr_t pad_coef();
        coef_arr_t c;
        for (int k = 0; k < MAX_TAPS; k++) c[k] = '0;
        for (int k = 0; k < int'(N_TAPS); k++) c[k] = coef_t'(COEF[k]);
        return c;
    endfunction

    localparam coef_arr_t COEFS = pad_coef();

    logic signed [ACC_W-1:0] lut [2**N_TAPS];

    for (genvar a = 0; a < 2**N_TAPS; a++) begin : g_entry
        localparam logic signed [ACC_W-1:0] ENTRY = ACC_W'(lut_entry(a, COEFS));
        assign lut[a] = ENTRY;
    end

    assign value = lut[addr];

endmodule

// File: rtl/da_dct_mac.sv
// Bit-serial distributed-arithmetic MAC for one DCT coefficient, LSB first.
// Optional DA_ROUND_EN: round-half-up instead of floor when scaling the result.
module da_dct_mac
    import da_dct_pkg::*;
#(
    parameter int unsigned N_TAPS = 4,
    parameter int unsigned IN_W   = 12,
    parameter int unsigned COEF_W = 16,
    parameter int unsigned FRAC   = 14,
    parameter int unsigned OUT_W  = 16,
    parameter logic signed [COEF_W-1:0] COEF [N_TAPS] =
        '{16'sh2D41, 16'shD2BF, 16'shD2BF, 16'sh2D41}
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_TAPS*IN_W-1:0]   in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_sat
);

    localparam int unsigned ACC_W = IN_W + COEF_W + N_TAPS;
    localparam int unsigned BW    = $clog2(IN_W);
    localparam logic [BW-1:0] LAST = BW'(IN_W - 1);
    localparam logic signed [ACC_W:0] OUT_MAX = (ACC_W+1)'((2**(OUT_W-1)) - 1);
    localparam logic signed [ACC_W:0] OUT_MIN = -OUT_MAX - 1;
`ifdef DA_ROUND_EN
    localparam logic signed [ACC_W:0] RND = (ACC_W+1)'(1 << (FRAC - 1));
`endif

    da_state_e               state_q, state_d;
    logic [IN_W-1:0]         sreg_q [N_TAPS];
    logic [IN_W-1:0]         sreg_d [N_TAPS];
    logic [BW-1:0]           bcnt_q, bcnt_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, lut_val, term;
    logic [N_TAPS-1:0]       lut_addr;
    logic                    load_out;
    logic signed [ACC_W:0]   acc_ext, r;
    logic [OUT_W-1:0]        res, out_data_q;
    logic                    sat, out_sat_q;

    always_comb begin
        for (int k = 0; k < int'(N_TAPS); k++) lut_addr[k] = sreg_q[k][0];
    end

    da_lut #(
        .N_TAPS (N_TAPS),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W),
        .COEF   (COEF)
    ) u_lut (
        .addr  (lut_addr),
        .value (lut_val)
    );

    assign term = lut_val <<< bcnt_q;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        sreg_d   = sreg_q;
        bcnt_d   = bcnt_q;
        load_out = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    for (int k = 0; k < int'(N_TAPS); k++) sreg_d[k] = in_data[k*IN_W +: IN_W];
                    acc_d   = '0;
                    bcnt_d  = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                for (int k = 0; k < int'(N_TAPS); k++) sreg_d[k] = sreg_q[k] >> 1;
                // The sign bit carries negative weight in two's complement.
                if (bcnt_q == LAST) begin
                    acc_d    = acc_q - term;
                    load_out = 1'b1;
                    state_d  = DONE;
                end else begin
                    acc_d  = acc_q + term;
                    bcnt_d = bcnt_q + BW'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
`ifdef DA_ROUND_EN
        acc_ext = (ACC_W+1)'(acc_d) + RND;
`else
        acc_ext = (ACC_W+1)'(acc_d);
`endif
        r   = acc_ext >>> FRAC;
        sat = 1'b0;
        res = r[OUT_W-1:0];
        if (r > OUT_MAX) begin
            res = OUT_MAX[OUT_W-1:0];
            sat = 1'b1;
        end else if (r < OUT_MIN) begin
            res = OUT_MIN[OUT_W-1:0];
            sat = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            bcnt_q     <= '0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
            for (int k = 0; k < int'(N_TAPS); k++) sreg_q[k] <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            bcnt_q  <= bcnt_d;
            sreg_q  <= sreg_d;
            if (load_out) begin
                out_data_q <= res;
                out_sat_q  <= sat;
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_da_dct_mac.sv
// Directed bench for da_dct_mac: default build plus a 12-bit saturating instance.
module tb_da_dct_mac;

`ifdef DA_ROUND_EN
    localparam int E_100 = 71;
    localparam int E_MIN = -1448;
    localparam int E_T12 = -1;
`else
    localparam int E_100 = 70;
    localparam int E_MIN = -1449;
    localparam int E_T12 = -2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_sat_a;
    logic [47:0] in_data_a;
    logic [15:0] out_data_a;
    logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_sat_b;
    logic [47:0] in_data_b;
    logic [11:0] out_data_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    da_dct_mac u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_a),
        .in_ready  (in_ready_a),
        .in_data   (in_data_a),
        .out_valid (out_valid_a),
        .out_ready (out_ready_a),
        .out_data  (out_data_a),
        .out_sat   (out_sat_a)
    );

    da_dct_mac #(
        .OUT_W (12),
        .COEF  ('{16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 16'sh7FFF})
    ) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_b),
        .in_ready  (in_ready_b),
        .in_data   (in_data_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready_b),
        .out_data  (out_data_b),
        .out_sat   (out_sat_b)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic [47:0] pack(input int x0, input int x1, input int x2, input int x3);
        return {12'(x3), 12'(x2), 12'(x1), 12'(x0)};
    endfunction

    task automatic run_vec(input string tag, input bit sel, input logic [47:0] d,
                           input int exp_data, input int exp_sat);
        int n;
        n = 1;
        @(negedge clk);
        if (sel) begin
            check({tag, " in_ready"}, int'(in_ready_b), 1);
            in_data_b  = d;
            in_valid_b = 1'b1;
        end else begin
            check({tag, " in_ready"}, int'(in_ready_a), 1);
            in_data_a  = d;
            in_valid_a = 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        while (!(sel ? out_valid_b : out_valid_a) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, " latency"}, n, 13);
        if (sel) begin
            check({tag, " data"}, int'($signed(out_data_b)), exp_data);
            check({tag, " sat"}, int'(out_sat_b), exp_sat);
        end else begin
            check({tag, " data"}, int'($signed(out_data_a)), exp_data);
            check({tag, " sat"}, int'(out_sat_a), exp_sat);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        bit seen;
        rst         = 1'b1;
        in_valid_a  = 1'b0;
        in_valid_b  = 1'b0;
        in_data_a   = '0;
        in_data_b   = '0;
        out_ready_a = 1'b1;
        out_ready_b = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset in_ready", int'(in_ready_a), 1);
        check("reset out_valid", int'(out_valid_a), 0);
        check("reset out_data", int'(out_data_a), 0);
        check("reset out_sat", int'(out_sat_a), 0);

        run_vec("tap0_100", 1'b0, pack(100, 0, 0, 0), E_100, 0);
        run_vec("tap0_min", 1'b0, pack(-2048, 0, 0, 0), E_MIN, 0);
        run_vec("ones", 1'b0, pack(1, 1, 1, 1), 0, 0);
        run_vec("taps12", 1'b0, pack(0, 1, 1, 0), E_T12, 0);
        run_vec("tap3_m100", 1'b0, pack(0, 0, 0, -100), -71, 0);
        run_vec("sat_pos", 1'b1, pack(2047, 2047, 2047, 2047), 2047, 1);
        run_vec("sat_neg", 1'b1, pack(-2048, -2048, -2048, -2048), -2048, 1);

        // Backpressure in DONE
        out_ready_a = 1'b0;
        @(negedge clk);
        in_data_a  = pack(100, 0, 0, 0);
        in_valid_a = 1'b1;
        @(posedge clk);
        #1 in_valid_a = 1'b0;
        n = 0;
        while (!out_valid_a && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("stall valid", int'(out_valid_a), 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall hold valid", int'(out_valid_a), 1);
            check("stall hold data", int'($signed(out_data_a)), E_100);
            check("stall in_ready", int'(in_ready_a), 0);
        end
        @(negedge clk);
        out_ready_a = 1'b1;
        @(posedge clk);
        #1;
        check("release valid", int'(out_valid_a), 0);
        check("release in_ready", int'(in_ready_a), 1);

        // Reset mid-SHIFT discards the vector
        @(negedge clk);
        in_data_a  = pack(100, 0, 0, 0);
        in_valid_a = 1'b1;
        @(posedge clk);
        #1 in_valid_a = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst in_ready", int'(in_ready_a), 1);
        check("midrst out_valid", int'(out_valid_a), 0);
        check("midrst out_data", int'(out_data_a), 0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid_a) seen = 1'b1;
        end
        check("midrst no output", int'(seen), 0);
        run_vec("after_rst", 1'b0, pack(100, 0, 0, 0), E_100, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
